// File: rtl/ctrl_ascensor_if.sv
// Request and car-position counter bus between the button logic,
// the up/down counter and the elevator sequencing controller.
interface ctrl_ascensor_if;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_err;
  logic [3:0] cnt_q;
  logic       cnt_enb;
  logic       cnt_modo;
  logic       cnt_load;
  logic [3:0] cnt_data;

  modport master (
    output req_valid, req_floor, cnt_q,
    input  req_err, cnt_enb, cnt_modo,
    input  cnt_load, cnt_data
  );

  modport slave (
    input  req_valid, req_floor, cnt_q,
    output req_err, cnt_enb, cnt_modo,
    output cnt_load, cnt_data
  );
endinterface

// File: rtl/ctrl_ascensor.sv
// Elevator sequencing controller: SCAN scheduling of latched floor
// requests, one counter step per floor, timed door-open interval.
module ctrl_ascensor #(
  parameter int NUM_FLOORS  = 8,
  parameter int STEP_CYCLES = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_ascensor_if.slave        bus,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [2:0] {
    INIT, IDLE, TRAVEL, PULSE, CHECK, DOOR
  } state_t;

  localparam int MAXC = (STEP_CYCLES > DOOR_CYCLES) ?
                        STEP_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [4:0]    NF      = 5'(NUM_FLOORS);
  localparam logic [TW-1:0] STEP_LD = TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LD = TW'(DOOR_CYCLES - 1);

  state_t                state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic                  dir_n;
  logic                  err_q, err_n;
  logic [NUM_FLOORS-1:0] pend_n;

  logic [15:0] pend16, set16, clr16;
  logic        cur_ok, at_pend, up_any, dn_any;
  logic        fwd, back;
  logic        req_ok, req_here, hold;
  logic        set, clr;

  // 16-bit view of the bitmap so a 4-bit floor always indexes it
  assign pend16   = 16'(pending);
  assign cur_ok   = {1'b0, bus.cnt_q} < NF;
  assign at_pend  = cur_ok && pend16[bus.cnt_q];
  assign up_any   = |(pend16 & (16'hFFFE << bus.cnt_q));
  assign dn_any   = |(pend16 & ~(16'hFFFF << bus.cnt_q));
  assign fwd      = dir_up ? up_any : dn_any;
  assign back     = dir_up ? dn_any : up_any;
  assign req_ok   = bus.req_valid &&
                    ({1'b0, bus.req_floor} < NF);
  assign req_here = req_ok && (bus.req_floor == bus.cnt_q);
  assign hold     = (state == IDLE) || (state == DOOR);

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    dir_n   = dir_up;
    clr     = 1'b0;
    set     = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      INIT: state_n = IDLE;
      IDLE: begin
        if (!cur_ok) begin
          state_n = INIT;
        end else if (at_pend || req_here) begin
          clr     = at_pend;
          state_n = DOOR;
          tmr_n   = DOOR_LD;
        end else if (fwd) begin
          state_n = TRAVEL;
          tmr_n   = STEP_LD;
        end else if (back) begin
          dir_n   = ~dir_up;
          state_n = TRAVEL;
          tmr_n   = STEP_LD;
        end
      end
      TRAVEL: begin
        if (tmr == '0) state_n = PULSE;
        else           tmr_n   = tmr - 1'b1;
      end
      PULSE: state_n = CHECK;
      CHECK: begin
        if (!cur_ok) begin
          state_n = INIT;
        end else if (at_pend) begin
          clr     = 1'b1;
          state_n = DOOR;
          tmr_n   = DOOR_LD;
        end else if (fwd) begin
          state_n = TRAVEL;
          tmr_n   = STEP_LD;
        end else begin
          state_n = IDLE;
        end
      end
      DOOR: begin
        if (req_here)        tmr_n   = DOOR_LD;
        else if (tmr == '0)  state_n = IDLE;
        else                 tmr_n   = tmr - 1'b1;
      end
      default: state_n = INIT;
    endcase
    if (state != INIT) begin
      err_n = bus.req_valid && !req_ok;
      set   = req_ok && !(req_here && hold);
    end
  end

  // a stop clears its own bit even if requested on the same edge
  assign set16  = set ? (16'd1 << bus.req_floor) : 16'd0;
  assign clr16  = clr ? (16'd1 << bus.cnt_q) : 16'd0;
  assign pend_n = (pending | set16[NUM_FLOORS-1:0]) &
                  ~clr16[NUM_FLOORS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      tmr     <= '0;
      dir_up  <= 1'b1;
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      dir_up  <= dir_n;
      pending <= pend_n;
      err_q   <= err_n;
    end
  end

  assign bus.cnt_load = (state == INIT);
  assign bus.cnt_data = 4'd0;
  assign bus.cnt_enb  = (state == PULSE);
  assign bus.cnt_modo = dir_up;
  assign bus.req_err  = err_q;
  assign door_open    = (state == DOOR);
  assign moving       = (state == TRAVEL) ||
                        (state == PULSE)  ||
                        (state == CHECK);

endmodule

// File: tb/tb_ctrl_ascensor.sv
// Scoreboard bench for ctrl_ascensor with a behavioural up/down
// counter closing the car-position loop.
module tb_ctrl_ascensor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       door_open, moving, dir_up;
  logic [7:0] pending;
  logic [3:0] cq = 4'd5;

  ctrl_ascensor_if bus ();

  ctrl_ascensor #(
    .NUM_FLOORS (8),
    .STEP_CYCLES(2),
    .DOOR_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .door_open(door_open),
    .moving   (moving),
    .dir_up   (dir_up),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.cnt_load)     cq <= bus.cnt_data;
    else if (bus.cnt_enb) cq <= bus.cnt_modo ? cq + 4'd1 : cq - 4'd1;
  end
  assign bus.cnt_q = cq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_stop[$];
  int pulse_cyc[$];
  int pulse_modo[$];
  int door_len_last = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops the expected floor whenever a stop begins
  initial begin
    logic door_q;
    int   dcnt;
    door_q = 1'b0;
    dcnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (door_open && !door_q) begin
          if (exp_stop.size() == 0)
            chk("stop_unexpected", int'(cq), -1);
          else
            chk("stop_floor", int'(cq), exp_stop.pop_front());
        end
        if (door_open) dcnt = door_q ? dcnt + 1 : 1;
        else if (door_q) door_len_last = dcnt;
        if (bus.cnt_enb) begin
          pulse_cyc.push_back(cyc);
          pulse_modo.push_back(int'(bus.cnt_modo));
          chk("step_bound",
              int'((bus.cnt_modo && cq == 4'd7) ||
                   (!bus.cnt_modo && cq == 4'd0)), 0);
        end
      end
      door_q = door_open;
    end
  end

  task automatic req(input int f);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_floor = 4'(f);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget && !(!moving && !door_open &&
           pending == 8'd0 && exp_stop.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("idle_timeout", n, -1);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_floor = 4'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_load", int'(bus.cnt_load), 1);
    chk("rst_data", int'(bus.cnt_data), 0);
    chk("rst_enb", int'(bus.cnt_enb), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_err", int'(bus.req_err), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_pending", int'(pending), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_after_rst", int'(bus.cnt_load), 1);
    @(negedge clk);
    chk("idle_no_load", int'(bus.cnt_load), 0);
    repeat (20) @(negedge clk);
    chk("idle_pulses", pulse_cyc.size(), 0);
    chk("idle_floor", int'(cq), 0);
    chk("idle_pending", int'(pending), 0);

    // single request 0 -> 3
    exp_stop.push_back(3);
    req(3);
    wait_idle(200);
    chk("up3_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("up3_gap1", pulse_cyc[1] - pulse_cyc[0], 4);
      chk("up3_gap2", pulse_cyc[2] - pulse_cyc[1], 4);
    end
    foreach (pulse_modo[i]) chk("up3_modo", pulse_modo[i], 1);
    chk("up3_door_len", door_len_last, 4);
    chk("up3_pending", int'(pending), 0);

    // back to 0, then SCAN: request 5, add 1 and 4 at floor 2
    exp_stop.push_back(0);
    req(0);
    wait_idle(200);
    exp_stop.push_back(4);
    exp_stop.push_back(5);
    exp_stop.push_back(1);
    req(5);
    n = 0;
    while (n < 100 && cq != 4'd2) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("scan_reach2", n, -1);
    req(1);
    req(4);
    wait_idle(400);
    chk("scan_dir", int'(dir_up), 0);
    chk("scan_floor", int'(cq), 1);

    // current-floor request and re-request during DOOR
    exp_stop.push_back(1);
    req(1);
    @(negedge clk);
    req(1);
    wait_idle(100);
    chk("here_door_len", door_len_last, 7);
    chk("here_pending", int'(pending), 0);

    // illegal floor
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_floor = 4'd9;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("err_pulse", int'(bus.req_err), 1);
    chk("err_pending", int'(pending), 0);
    @(negedge clk);
    chk("err_once", int'(bus.req_err), 0);
    chk("err_still", int'(moving | door_open), 0);

    // full span 1 -> 7 -> 0
    pulse_cyc.delete();
    exp_stop.push_back(7);
    req(7);
    wait_idle(400);
    exp_stop.push_back(0);
    req(0);
    wait_idle(400);
    chk("span_pulses", pulse_cyc.size(), 13);
    chk("span_floor", int'(cq), 0);

    // reset during PULSE
    req(5);
    n = 0;
    while (n < 100 && !bus.cnt_enb) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("mid_pulse_seen", n, -1);
    #1 rst = 1'b1;
    #1;
    chk("mid_enb", int'(bus.cnt_enb), 0);
    chk("mid_pending", int'(pending), 0);
    chk("mid_load", int'(bus.cnt_load), 1);
    pulse_cyc.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_floor", int'(cq), 0);
    chk("mid_no_motion", pulse_cyc.size(), 0);
    chk("mid_moving", int'(moving | door_open), 0);
    chk("sb_empty", exp_stop.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ctrl_ascensor.md
# ctrl_ascensor

Elevator sequencing controller that owns the 4-bit up/down counter used as the car-position register. It latches floor requests into a pending bitmap, schedules them with a SCAN policy (keep direction while work remains ahead), and drives the counter's enb/modo/load/data inputs one floor per step. It also times the door-open interval. It sits between the request/button logic and the counter datapath.

## Interface
- NUM_FLOORS, 8, number of served floors, legal 2..16; floors 0..NUM_FLOORS-1
- STEP_CYCLES, 2, cycles spent in TRAVEL per floor step, legal >= 1
- DOOR_CYCLES, 4, cycles door_open is held per stop, legal >= 1

- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  floor request strobe, sampled every rising edge
- req_floor  input  4  requested floor
- req_err  output  1  registered 1-cycle pulse: previous req had req_floor >= NUM_FLOORS
- cnt_q  input  4  counter output (current floor)
- cnt_enb  output  1  counter enable, one-cycle pulse per floor step
- cnt_modo  output  1  counter direction, 1 = up, 0 = down
- cnt_load  output  1  counter synchronous load of cnt_data
- cnt_data  output  4  load value, always 0
- door_open  output  1  door held open
- moving  output  1  high in TRAVEL, PULSE, CHECK
- dir_up  output  1  current scheduling direction
- pending  output  NUM_FLOORS  latched, unserved requests

## Operation
- Counter contract: on a rising edge with cnt_load=1, Q<=cnt_data; else with cnt_enb=1, Q<=Q+1 (modo=1) or Q-1 (modo=0). cnt_q is valid the cycle after the pulse.
- States: INIT, IDLE, TRAVEL, PULSE, CHECK, DOOR. Outputs are Moore-decoded from state; dir_up, pending and req_err are registers.
- INIT: cnt_load=1, cnt_data=0. The next state is always IDLE.
- IDLE:
  - pending[cnt_q] set: clear it, go to DOOR.
  - Else, if any pending in direction dir_up: go to TRAVEL.
  - Else, if any pending in the opposite direction: toggle dir_up, go to TRAVEL.
  - Else, stay in IDLE.
- TRAVEL: runs STEP_CYCLES cycles, then goes to PULSE.
- PULSE: cnt_enb=1, cnt_modo=dir_up for 1 cycle, then goes to CHECK.
- CHECK:
  - pending[cnt_q] set: clear it, go to DOOR.
  - Else, if pending exists beyond cnt_q in dir_up: go to TRAVEL.
  - Else: go to IDLE.
- DOOR: door_open=1 for DOOR_CYCLES cycles, then go to IDLE.
- Request capture, applied at every edge in every state except INIT:
  - req_floor >= NUM_FLOORS: ignored, req_err pulses.
  - req_floor == cnt_q while in IDLE or DOOR: not latched. In IDLE it forces DOOR; in DOOR it restarts the door timer.
  - Otherwise: pending[req_floor] <= 1.
- Same-edge set and clear of the same bit: clear wins, because the request counts as served by the stop.
- Requests presented in INIT are dropped.
- Boundaries:
  - The controller never pulses up at NUM_FLOORS-1 or down at 0, because it only moves toward a pending floor.
  - cnt_q >= NUM_FLOORS observed in IDLE or CHECK: go to INIT (reload 0) and keep pending.

## Timing
- Reset asserted, at any time including mid-travel:
  - State goes to INIT immediately.
  - Outputs: cnt_load=1, cnt_data=0.
  - cnt_enb, door_open, moving and req_err are 0.
  - dir_up=1, pending=0.
- First cycle after reset release: still INIT (counter loaded at that edge). Second cycle: IDLE.
- Request latency, with cycle 0 = req_valid high while IDLE at floor f, request for f+1:
  - Cycle 1: IDLE with pending set.
  - Cycles 2..1+STEP_CYCLES: TRAVEL.
  - Next cycle: PULSE.
  - Next cycle: CHECK, with cnt_q = f+1.
  - Then DOOR_CYCLES cycles of door_open.
- Per floor of travel: STEP_CYCLES+2 cycles (TRAVEL, PULSE, CHECK).
- req_err is high exactly one cycle after the bad request.

## Test plan
- Reset then idle:
  - cnt_load=1 during and one cycle after rst.
  - cnt_q=0, pending=0, no cnt_enb for 20 cycles.
- Single request, floor 0, req_floor=3, defaults:
  - Exactly 3 cnt_enb pulses with cnt_modo=1, each 4 cycles apart.
  - door_open for 4 cycles at cnt_q=3.
  - pending returns to 0.
- SCAN ordering: at floor 0 request 5; while travelling (cnt_q=2) request 1 and 4:
  - Stops occur in order 4, 5, 1.
  - dir_up toggles to 0 after stop 5.
  - No stop at 1 on the way up.
- Current-floor and re-request:
  - req_floor=cnt_q in IDLE: opens door.
  - Repeated during DOOR: door_open extends to 4 cycles after the last request.
  - pending stays 0.
- Illegal and edge floors, NUM_FLOORS=8:
  - req_floor=9: req_err pulses, pending unchanged.
  - Travel 0 to 7 and back to 0: cnt_q never exceeds 7 or underflows.
- Reset mid-travel: rst asserted during PULSE:
  - cnt_enb drops immediately and pending clears.
  - Counter is reloaded to 0.
  - After release, no motion until a new request.
